// File: rtl/io_trace_buffer.sv
// io_trace_buffer
// Wishbone-readable trace capture of the 36-bit design output bus. The bus is
// sampled every cycle. When capture is enabled, an entry {timestamp, sample}
// is pushed into a FIFO, either on every cycle or only when the sample changes.
// Firmware drains the FIFO through the register window.
//
// Ports:
//   wb_clk_i       single clock for all logic
//   rst_n          asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i   Wishbone slave request
//   wbs_ack_o      one-cycle acknowledge for accesses decoded to this block
//   wbs_dat_o      registered read data, zero outside the ack cycle
//   io_out_design  36-bit design output bus being traced
//   trace_irq      CTRL.irq_en & FIFO not empty
//
// Register map (offset = wbs_adr_i[3:2]):
//   0 CTRL    [0] enable [1] change_only [2] clear (pulse, reads 0) [3] irq_en
//   1 STATUS  [4:0] count [8] empty [9] full [10] overflow (sticky)
//   2 DATA_LO head io[31:0]
//   3 DATA_HI [3:0] head io[35:32], [27:16] head timestamp; reading pops
module io_trace_buffer #(
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0100,
    parameter int          DEPTH_LOG2 = 4,
    parameter int          TS_W       = 12
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [35:0] io_out_design,
    output logic        trace_irq
);

    localparam int IO_W    = 36;
    localparam int ENTRY_W = TS_W + IO_W;
    localparam int DEPTH   = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
    localparam logic [TS_W-1:0]       TS_ZERO  = {TS_W{1'b0}};
    localparam logic [TS_W-1:0]       TS_ONE   = {{(TS_W - 1){1'b0}}, 1'b1};

    // Registers
    logic                  ctrl_en_r, ctrl_chg_r, ctrl_irq_en_r, clear_pend_r;
    logic [IO_W-1:0]       sample_r, last_r;
    logic [TS_W-1:0]       ts_r;
    logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  ovf_r, ack_r, irq_r;
    logic [31:0]           dat_r;
    logic [ENTRY_W-1:0]    mem_r [DEPTH];

    // Combinational next-state and decode
    logic                  sel_s, ctrl_wr_s, pop_req_s, push_req_s;
    logic                  do_push_s, do_pop_s, empty_s, full_s;
    logic                  irq_en_nx_s, ovf_nx_s;
    logic [DEPTH_LOG2:0]   count_nx_s;
    logic [DEPTH_LOG2-1:0] wr_ptr_nx_s, rd_ptr_nx_s;
    logic [TS_W-1:0]       ts_nx_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [31:0]           status_s, data_hi_s, rd_mux_s;
    logic                  unused_s;

    assign unused_s = ^{wbs_adr_i[7:4], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:4]};

    // Bus decode; a new access is refused during the ack cycle
    always_comb begin
        sel_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]) & ~ack_r;
        empty_s   = (count_r == CNT_ZERO);
        full_s    = (count_r == CNT_FULL);
        ctrl_wr_s = sel_s & wbs_we_i & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0];
        pop_req_s = sel_s & ~wbs_we_i & (wbs_adr_i[3:2] == 2'd3) & ~empty_s;
    end

    // Read data mux; data registers read as zero while the FIFO is empty
    always_comb begin
        head_s               = mem_r[rd_ptr_r];
        status_s             = 32'h0000_0000;
        status_s[DEPTH_LOG2:0] = count_r;
        status_s[8]          = empty_s;
        status_s[9]          = full_s;
        status_s[10]         = ovf_r;
        data_hi_s            = 32'h0000_0000;
        data_hi_s[3:0]       = head_s[IO_W-1:32];
        data_hi_s[16 +: TS_W] = head_s[ENTRY_W-1:IO_W];
        case (wbs_adr_i[3:2])
            2'd0:    rd_mux_s = {28'h000_0000, ctrl_irq_en_r, 1'b0, ctrl_chg_r, ctrl_en_r};
            2'd1:    rd_mux_s = status_s;
            2'd2:    rd_mux_s = empty_s ? 32'h0000_0000 : head_s[31:0];
            2'd3:    rd_mux_s = empty_s ? 32'h0000_0000 : data_hi_s;
            default: rd_mux_s = 32'h0000_0000;
        endcase
    end

    // FIFO / timestamp next state; a pending clear overrides push and pop
    always_comb begin
        push_req_s  = ctrl_en_r & (~ctrl_chg_r | (sample_r != last_r));
        irq_en_nx_s = ctrl_wr_s ? wbs_dat_i[3] : ctrl_irq_en_r;
        if (clear_pend_r) begin
            do_push_s   = 1'b0;
            do_pop_s    = 1'b0;
            ovf_nx_s    = 1'b0;
            ts_nx_s     = TS_ZERO;
            wr_ptr_nx_s = PTR_ZERO;
            rd_ptr_nx_s = PTR_ZERO;
            count_nx_s  = CNT_ZERO;
        end else begin
            do_pop_s    = pop_req_s;
            // a pop in the same cycle frees the slot, so a full FIFO still accepts
            do_push_s   = push_req_s & (~full_s | pop_req_s);
            ovf_nx_s    = ovf_r | (push_req_s & full_s & ~pop_req_s);
            ts_nx_s     = ctrl_en_r ? (ts_r + TS_ONE) : ts_r;
            wr_ptr_nx_s = do_push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_nx_s = do_pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_nx_s = count_r + CNT_ONE;
                2'b01:   count_nx_s = count_r - CNT_ONE;
                default: count_nx_s = count_r;
            endcase
        end
    end

    // Control, capture and bus state registers
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_r     <= 1'b0;
            ctrl_chg_r    <= 1'b0;
            ctrl_irq_en_r <= 1'b0;
            clear_pend_r  <= 1'b0;
            sample_r      <= {IO_W{1'b0}};
            last_r        <= {IO_W{1'b0}};
            ts_r          <= TS_ZERO;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            ovf_r         <= 1'b0;
            ack_r         <= 1'b0;
            dat_r         <= 32'h0000_0000;
            irq_r         <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                ctrl_en_r  <= wbs_dat_i[0];
                ctrl_chg_r <= wbs_dat_i[1];
            end
            ctrl_irq_en_r <= irq_en_nx_s;
            clear_pend_r  <= ctrl_wr_s & wbs_dat_i[2];
            sample_r      <= io_out_design;
            if (ctrl_en_r) begin
                last_r <= sample_r;
            end
            ts_r     <= ts_nx_s;
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            count_r  <= count_nx_s;
            ovf_r    <= ovf_nx_s;
            ack_r    <= sel_s;
            dat_r    <= (sel_s & ~wbs_we_i) ? rd_mux_s : 32'h0000_0000;
            irq_r    <= irq_en_nx_s & (count_nx_s != CNT_ZERO);
        end
    end

    // FIFO storage; contents are only visible while count is non-zero
    always_ff @(posedge wb_clk_i) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= {ts_r, sample_r};
        end
    end

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;
    assign trace_irq = irq_r;

endmodule

// File: doc/io_trace_buffer.md
Name: io_trace_buffer

Overview:
- Wishbone-readable trace capture of the selected design's 36-bit io_out bus (the same bus the multiplexer routes to the pads).
- Samples the bus every cycle and pushes an entry on each change, or on every cycle, into a 16-deep FIFO. Each entry is tagged with a 12-bit timestamp.
- Sits beside the multiplexer on the Wishbone bus, downstream of the design outputs. Lets firmware debug a design without an external logic analyzer.

Parameters:
- ADDR_BASE, 32'h3000_0100: Wishbone base address. Compare bits [31:8] only.
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 entries (16).
- TS_W, 12: timestamp counter width.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge. Asserted only for accesses to this block.
- wbs_dat_o  out  32  read data. Zero when not acking.
- io_out_design  in  36  design output bus being traced.
- trace_irq  out  1  interrupt: CTRL.irq_en & ~empty.

Behaviour:
- Reset: CTRL=0, FIFO empty (count=0), overflow=0, timestamp=0, last-sample register=0, wbs_ack_o=0, wbs_dat_o=0, trace_irq=0.
- Register map (offset = wbs_adr_i[3:2]):
  - 0x0 CTRL, RW. Bit0 enable, bit1 change_only, bit2 clear (write-1 pulse, reads 0), bit3 irq_en. Written only when wbs_sel_i[0]=1.
  - 0x4 STATUS, RO. [4:0] count (0..16), bit8 empty, bit9 full, bit10 overflow (sticky).
  - 0x8 DATA_LO, RO. Head entry io[31:0]. No side effect.
  - 0xC DATA_HI, RO. [3:0] head io[35:32], [27:16] head timestamp. Reading it pops the head if not empty.
  - Any read when empty returns 0. Writes to RO registers are acked and ignored.
- Wishbone timing:
  - Selected access: cyc&stb with adr[31:8]==ADDR_BASE[31:8].
  - Ack rises the cycle after a selected access is seen and stays high for exactly 1 cycle.
  - The block does not accept a new access in the ack cycle, so there are no back-to-back acks and each access gives exactly one ack.
  - Read data is registered and valid in the ack cycle. A pop takes effect at the ack edge.
- Capture pipeline:
  - io_out_design is registered every cycle (sample stage, 1 cycle latency).
  - When enable=1, timestamp increments every cycle and wraps 0xFFF->0x000.
  - Push condition: enable & (~change_only | sample != last_sample).
  - last_sample updates on every enabled cycle.
  - First entry after enable: last_sample is compared as-is, with no forced push.
  - Entry = {timestamp, sample}, 48 bits.
- FIFO boundaries:
  - Push when full: the entry is dropped and overflow is set.
  - Push and pop in the same cycle: both happen and count is unchanged. When full this still succeeds, with no overflow.
  - Pop when empty: no-op.
  - Pointers wrap modulo 16.
- Clear:
  - Empties the FIFO and zeroes timestamp and overflow in the cycle after the write ack.
  - Clear has priority over a push or pop in the same cycle.
  - enable/change_only/irq_en keep the written values.
- Disable (enable=0): no pushes, timestamp holds, FIFO contents stay readable.
- Asynchronous reset mid-transaction: ack drops immediately and the FIFO is emptied. The master will re-issue.

Test Plan:
- Reset, then read STATUS -> 0x0000_0100 (empty). Read DATA_HI -> 0. Ack is one cycle per access.
- CTRL=0x3, drive io 0x0_0000_0001 then 0x0_0000_0002 five cycles later, hold -> count=2. Second timestamp minus first = 5. DATA_LO reads 1 then 2 across two DATA_HI pops.
- CTRL=0x1 (every cycle) for 20 cycles -> count=16, full=1, overflow=1. Pop 16 times -> empty=1, overflow remains 1.
- Full FIFO while capture continues: one DATA_HI read -> count stays 16, overflow not newly set by that push, popped entry is the oldest.
- io=0xF_0000_0000 with change_only -> DATA_HI[3:0]=0xF. Run 4096 enabled cycles -> timestamp wraps to its start value.
- Write CTRL=0xD (clear+irq_en+enable) on a non-empty FIFO -> count=0, overflow=0, trace_irq falls. The next change pushes and trace_irq rises.
